// File: rtl/fsm_state_monitor.sv
// fsm_state_monitor
// Passive checker that sits downstream of a small FSM and samples its state
// register on every qualified cycle. It flags illegal encodings, detects a
// state that dwells too long ("stuck"), counts transitions, and reports
// illegal/stuck events through a one-entry valid/ready report register.
//
// Optional feature: define FSM_MON_COVER_EN to build the per-state coverage
// registers (visited / all_visited). Without it both outputs are tied to 0.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   clr            synchronous clear of all state and flags (beats everything)
//   state_valid    qualifies state_in this cycle
//   state_in       monitored FSM state
//   illegal_state  one-cycle pulse: last valid sample was illegal
//   illegal_seen   sticky: any illegal sample since reset/clr
//   stuck          level: dwell count has reached STUCK_LIMIT
//   trans_cnt      saturating count of state changes
//   visited        bit i set once legal state i was sampled (coverage build)
//   all_visited    every legal state has been visited (coverage build)
//   rpt_valid/rpt_ready/rpt_code/rpt_state  report register handshake
//   rpt_ovf        sticky: an event was lost
module fsm_state_monitor #(
  parameter int STATE_W     = 2,
  parameter int NUM_STATES  = 3,
  parameter int STUCK_LIMIT = 8,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  state_valid,
  input  logic [STATE_W-1:0]    state_in,
  output logic                  illegal_state,
  output logic                  illegal_seen,
  output logic                  stuck,
  output logic [CNT_W-1:0]      trans_cnt,
  output logic [2**STATE_W-1:0] visited,
  output logic                  all_visited,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [1:0]            rpt_code,
  output logic [STATE_W-1:0]    rpt_state,
  output logic                  rpt_ovf
);

  localparam int DWELL_W = $clog2(STUCK_LIMIT + 1);
  localparam logic [DWELL_W-1:0] LIMIT = DWELL_W'(STUCK_LIMIT);
  // One extra bit so NUM_STATES == 2**STATE_W stays representable.
  localparam logic [STATE_W:0] NUM_ST = (STATE_W + 1)'(NUM_STATES);

  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_STUCK   = 2'b10;

  typedef enum logic {IDLE, TRACK} mon_state_e;

  mon_state_e          mon_state_q, mon_state_d;
  logic [STATE_W-1:0]  prev_q, prev_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [CNT_W-1:0]    trans_cnt_q, trans_cnt_d;
  logic                stuck_q, stuck_d;
  logic                illegal_q, illegal_d;
  logic                seen_q, seen_d;
  logic                rpt_valid_q, rpt_valid_d;
  logic [1:0]          rpt_code_q, rpt_code_d;
  logic [STATE_W-1:0]  rpt_state_q, rpt_state_d;
  logic                rpt_ovf_q, rpt_ovf_d;

  logic sample_illegal;
  logic ev_illegal;
  logic ev_stuck;

  assign sample_illegal = ({1'b0, state_in} >= NUM_ST);

  always_comb begin
    mon_state_d = mon_state_q;
    prev_d      = prev_q;
    dwell_d     = dwell_q;
    trans_cnt_d = trans_cnt_q;
    stuck_d     = stuck_q;
    illegal_d   = 1'b0;
    seen_d      = seen_q;
    rpt_valid_d = rpt_valid_q;
    rpt_code_d  = rpt_code_q;
    rpt_state_d = rpt_state_q;
    rpt_ovf_d   = rpt_ovf_q;
    ev_illegal  = 1'b0;
    ev_stuck    = 1'b0;

    if (state_valid) begin
      mon_state_d = TRACK;
      prev_d      = state_in;
      if (mon_state_q == IDLE) begin
        // First sample only establishes the reference state.
        dwell_d = DWELL_W'(1);
      end else if (state_in != prev_q) begin
        dwell_d = DWELL_W'(1);
        if (trans_cnt_q != '1) trans_cnt_d = trans_cnt_q + 1'b1;
      end else if (dwell_q != LIMIT) begin
        dwell_d = dwell_q + 1'b1;
      end
      stuck_d    = (dwell_d >= LIMIT);
      ev_stuck   = stuck_d && !stuck_q;
      ev_illegal = sample_illegal;
      illegal_d  = sample_illegal;
      if (sample_illegal) seen_d = 1'b1;
    end

    // Report register: a held report is only replaced when it is being
    // accepted in the same cycle; otherwise the new event is lost.
    if (ev_illegal && ev_stuck) rpt_ovf_d = 1'b1;
    if (ev_illegal || ev_stuck) begin
      if (!rpt_valid_q || rpt_ready) begin
        rpt_valid_d = 1'b1;
        rpt_code_d  = ev_illegal ? CODE_ILLEGAL : CODE_STUCK;
        rpt_state_d = state_in;
      end else begin
        rpt_ovf_d = 1'b1;
      end
    end else if (rpt_valid_q && rpt_ready) begin
      rpt_valid_d = 1'b0;
      rpt_code_d  = 2'b00;
      rpt_state_d = '0;
    end

    if (clr) begin
      mon_state_d = IDLE;
      prev_d      = '0;
      dwell_d     = '0;
      trans_cnt_d = '0;
      stuck_d     = 1'b0;
      illegal_d   = 1'b0;
      seen_d      = 1'b0;
      rpt_valid_d = 1'b0;
      rpt_code_d  = 2'b00;
      rpt_state_d = '0;
      rpt_ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_state_q <= IDLE;
      prev_q      <= '0;
      dwell_q     <= '0;
      trans_cnt_q <= '0;
      stuck_q     <= 1'b0;
      illegal_q   <= 1'b0;
      seen_q      <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_code_q  <= 2'b00;
      rpt_state_q <= '0;
      rpt_ovf_q   <= 1'b0;
    end else begin
      mon_state_q <= mon_state_d;
      prev_q      <= prev_d;
      dwell_q     <= dwell_d;
      trans_cnt_q <= trans_cnt_d;
      stuck_q     <= stuck_d;
      illegal_q   <= illegal_d;
      seen_q      <= seen_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_code_q  <= rpt_code_d;
      rpt_state_q <= rpt_state_d;
      rpt_ovf_q   <= rpt_ovf_d;
    end
  end

  assign illegal_state = illegal_q;
  assign illegal_seen  = seen_q;
  assign stuck         = stuck_q;
  assign trans_cnt     = trans_cnt_q;
  assign rpt_valid     = rpt_valid_q;
  assign rpt_code      = rpt_code_q;
  assign rpt_state     = rpt_state_q;
  assign rpt_ovf       = rpt_ovf_q;

`ifdef FSM_MON_COVER_EN
  logic [2**STATE_W-1:0] visited_q, visited_d;

  always_comb begin
    visited_d = visited_q;
    if (state_valid && !sample_illegal) visited_d[state_in] = 1'b1;
    if (clr) visited_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) visited_q <= '0;
    else        visited_q <= visited_d;
  end

  assign visited     = visited_q;
  assign all_visited = &visited_q[NUM_STATES-1:0];
`else
  assign visited     = '0;
  assign all_visited = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_state_monitor.sv
module tb_fsm_state_monitor;

  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       state_valid = 1'b0;
  logic [1:0] state_in = 2'd0;
  logic       rpt_ready = 1'b0;
  logic       illegal_state, illegal_seen, stuck, all_visited;
  logic       rpt_valid, rpt_ovf;
  logic [7:0] trans_cnt;
  logic [3:0] visited;
  logic [1:0] rpt_code, rpt_state;

  int n_cmp = 0;
  int n_fail = 0;

  fsm_state_monitor #(
    .STATE_W(2), .NUM_STATES(3), .STUCK_LIMIT(LIM), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .state_valid(state_valid), .state_in(state_in),
    .illegal_state(illegal_state), .illegal_seen(illegal_seen),
    .stuck(stuck), .trans_cnt(trans_cnt),
    .visited(visited), .all_visited(all_visited),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_code(rpt_code), .rpt_state(rpt_state), .rpt_ovf(rpt_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: run length is kept unbounded and stuck is derived
  // from it; the report slot is a simple "held event" record.
  bit   m_started;
  int   m_last, m_run, m_trans;
  bit   m_stuck, m_pulse, m_seen;
  bit   m_seen_state [4];
  bit   m_rv, m_ovf;
  int   m_code, m_rstate;
  logic [3:0] exp_vis;
  logic       exp_all;

  function automatic void model_clear();
    m_started = 0; m_last = 0; m_run = 0; m_trans = 0;
    m_stuck = 0; m_pulse = 0; m_seen = 0;
    for (int k = 0; k < 4; k++) m_seen_state[k] = 0;
    m_rv = 0; m_ovf = 0; m_code = 0; m_rstate = 0;
  endfunction

  function automatic void model_step(bit v, int s, bit rdy, bit c);
    bit ev_ill, ev_stk, now_stuck;
    ev_ill = 0; ev_stk = 0;
    if (c) begin
      model_clear();
      return;
    end
    m_pulse = 0;
    if (v) begin
      if (!m_started) begin
        m_started = 1; m_run = 1;
      end else if (s != m_last) begin
        m_run = 1;
        if (m_trans < 255) m_trans++;
      end else begin
        m_run++;
      end
      m_last = s;
      now_stuck = (m_run >= LIM);
      ev_stk = now_stuck && !m_stuck;
      m_stuck = now_stuck;
      ev_ill = (s >= 3);
      m_pulse = ev_ill;
      if (ev_ill) m_seen = 1;
      else m_seen_state[s] = 1;
    end
    if (ev_ill && ev_stk) m_ovf = 1;
    if (ev_ill || ev_stk) begin
      if (!m_rv || rdy) begin
        m_rv = 1; m_code = ev_ill ? 1 : 2; m_rstate = s;
      end else begin
        m_ovf = 1;
      end
    end else if (m_rv && rdy) begin
      m_rv = 0; m_code = 0; m_rstate = 0;
    end
  endfunction

  function automatic void model_expect_cov();
`ifdef FSM_MON_COVER_EN
    for (int k = 0; k < 4; k++) exp_vis[k] = m_seen_state[k];
    exp_all = m_seen_state[0] && m_seen_state[1] && m_seen_state[2];
`else
    exp_vis = 4'b0000;
    exp_all = 1'b0;
`endif
  endfunction

  // Apply one cycle of stimulus, then advance the model. Outputs are
  // sampled 1 time unit after the rising edge.
  task automatic step(input bit v, input logic [1:0] s, input bit rdy, input bit c);
    state_valid = v; state_in = s; rpt_ready = rdy; clr = c;
    @(posedge clk); #1;
    if (m_rv && rdy && !c)
      $display("report accepted: code=%0d state=%0d t=%0t", m_code, m_rstate, $time);
    model_step(v, int'(s), rdy, c);
    model_expect_cov();
    state_valid = 1'b0; clr = 1'b0; rpt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear(); model_expect_cov();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (trans_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_trans got=%0d exp=0", trans_cnt); end
    n_cmp++; if ({illegal_state, illegal_seen, stuck, rpt_valid, rpt_ovf} !== 5'b0) begin n_fail++;
      $display("FAIL reset_flags got=%b exp=00000", {illegal_state, illegal_seen, stuck, rpt_valid, rpt_ovf}); end
    n_cmp++; if ({rpt_code, rpt_state, visited, all_visited} !== 9'b0) begin n_fail++;
      $display("FAIL reset_rpt_cov got=%b exp=0", {rpt_code, rpt_state, visited, all_visited}); end
  endtask

  task automatic test_legal_walk();
    step(1, 2'd0, 0, 0); step(1, 2'd1, 0, 0); step(1, 2'd2, 0, 0); step(1, 2'd0, 0, 0);
    n_cmp++; if (trans_cnt !== 8'd3) begin n_fail++; $display("FAIL walk_trans got=%0d exp=3", trans_cnt); end
    n_cmp++; if (visited !== exp_vis) begin n_fail++; $display("FAIL walk_visited got=%b exp=%b", visited, exp_vis); end
    n_cmp++; if (all_visited !== exp_all) begin n_fail++; $display("FAIL walk_all got=%b exp=%b", all_visited, exp_all); end
    n_cmp++; if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL walk_rpt_valid got=%b exp=0", rpt_valid); end
  endtask

  task automatic test_illegal();
    step(1, 2'd3, 1, 0);
    n_cmp++; if ({illegal_state, illegal_seen} !== 2'b11) begin n_fail++;
      $display("FAIL ill_flags got=%b exp=11", {illegal_state, illegal_seen}); end
    n_cmp++; if ({rpt_valid, rpt_code, rpt_state} !== 5'b1_01_11) begin n_fail++;
      $display("FAIL ill_report got=%b exp=10111", {rpt_valid, rpt_code, rpt_state}); end
    n_cmp++; if (visited[3] !== 1'b0) begin n_fail++; $display("FAIL ill_visited3 got=%b exp=0", visited[3]); end
    step(0, 2'd0, 1, 0);
    n_cmp++; if ({illegal_state, illegal_seen} !== 2'b01) begin n_fail++;
      $display("FAIL ill_pulse_end got=%b exp=01", {illegal_state, illegal_seen}); end
    n_cmp++; if ({rpt_valid, rpt_code, rpt_state} !== 5'b0) begin n_fail++;
      $display("FAIL ill_accept got=%b exp=00000", {rpt_valid, rpt_code, rpt_state}); end
  endtask

  task automatic test_stuck_ovf();
    step(0, 2'd0, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 2'd1, 0, 0);
    n_cmp++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL stuck_early got=%b exp=0", stuck); end
    step(1, 2'd1, 0, 0);
    n_cmp++; if (stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_set got=%b exp=1", stuck); end
    n_cmp++; if ({rpt_valid, rpt_code, rpt_state} !== 5'b1_10_01) begin n_fail++;
      $display("FAIL stuck_report got=%b exp=11001", {rpt_valid, rpt_code, rpt_state}); end
    step(1, 2'd3, 0, 0);
    n_cmp++; if ({rpt_ovf, stuck} !== 2'b10) begin n_fail++; $display("FAIL ovf_set got=%b exp=10", {rpt_ovf, stuck}); end
    n_cmp++; if ({rpt_valid, rpt_code, rpt_state} !== 5'b1_10_01) begin n_fail++;
      $display("FAIL ovf_hold got=%b exp=11001", {rpt_valid, rpt_code, rpt_state}); end
  endtask

  task automatic test_back_to_back();
    step(0, 2'd0, 0, 1);
    step(1, 2'd3, 0, 0);
    step(1, 2'd3, 1, 0);
    n_cmp++; if ({rpt_valid, rpt_code, rpt_state, rpt_ovf} !== 6'b1_01_11_0) begin n_fail++;
      $display("FAIL b2b_reload got=%b exp=101110", {rpt_valid, rpt_code, rpt_state, rpt_ovf}); end
    step(0, 2'd0, 1, 0);
    n_cmp++; if ({rpt_valid, rpt_code, rpt_state} !== 5'b0) begin n_fail++;
      $display("FAIL b2b_drain got=%b exp=00000", {rpt_valid, rpt_code, rpt_state}); end
  endtask

  task automatic test_saturate_clr();
    step(0, 2'd0, 0, 1);
    for (int k = 0; k < 300; k++) step(1, 2'(k % 2), 1, 0);
    n_cmp++; if (trans_cnt !== 8'(m_trans) || m_trans != 255) begin n_fail++;
      $display("FAIL sat_trans got=%0d exp=255", trans_cnt); end
    step(1, 2'd3, 1, 1);
    n_cmp++; if ({trans_cnt, illegal_state, illegal_seen, stuck, rpt_valid, rpt_code, rpt_state, rpt_ovf, visited, all_visited} !== 23'b0) begin
      n_fail++; $display("FAIL clr_all trans=%0d flags=%b", trans_cnt, {illegal_state, illegal_seen, stuck, rpt_valid, rpt_ovf}); end
    step(1, 2'd2, 0, 0);
    n_cmp++; if (trans_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_idle_trans got=%0d exp=0", trans_cnt); end
    n_cmp++; if (visited !== exp_vis) begin n_fail++; $display("FAIL clr_idle_vis got=%b exp=%b", visited, exp_vis); end
  endtask

  task automatic test_random();
    logic [1:0] s;
    bit v, rdy, c;
    s = 2'd0;
    step(0, 2'd0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) s = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 99) == 0);
      step(v, s, rdy, c);
      n_cmp++; if (trans_cnt !== 8'(m_trans)) begin n_fail++; $display("FAIL rnd_trans cyc=%0d got=%0d exp=%0d", i, trans_cnt, m_trans); end
      n_cmp++; if (illegal_state !== m_pulse) begin n_fail++; $display("FAIL rnd_ill cyc=%0d got=%b exp=%b", i, illegal_state, m_pulse); end
      n_cmp++; if (illegal_seen !== m_seen) begin n_fail++; $display("FAIL rnd_seen cyc=%0d got=%b exp=%b", i, illegal_seen, m_seen); end
      n_cmp++; if (stuck !== m_stuck) begin n_fail++; $display("FAIL rnd_stuck cyc=%0d got=%b exp=%b", i, stuck, m_stuck); end
      n_cmp++; if (rpt_valid !== m_rv) begin n_fail++; $display("FAIL rnd_rv cyc=%0d got=%b exp=%b", i, rpt_valid, m_rv); end
      n_cmp++; if (rpt_code !== 2'(m_code)) begin n_fail++; $display("FAIL rnd_code cyc=%0d got=%0d exp=%0d", i, rpt_code, m_code); end
      n_cmp++; if (rpt_state !== 2'(m_rstate)) begin n_fail++; $display("FAIL rnd_rstate cyc=%0d got=%0d exp=%0d", i, rpt_state, m_rstate); end
      n_cmp++; if (rpt_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, rpt_ovf, m_ovf); end
      n_cmp++; if (visited !== exp_vis) begin n_fail++; $display("FAIL rnd_vis cyc=%0d got=%b exp=%b", i, visited, exp_vis); end
      n_cmp++; if (all_visited !== exp_all) begin n_fail++; $display("FAIL rnd_all cyc=%0d got=%b exp=%b", i, all_visited, exp_all); end
    end
  endtask

  task automatic test_async_reset();
    step(0, 2'd0, 0, 1);
    step(1, 2'd0, 0, 0); step(1, 2'd1, 0, 0); step(1, 2'd3, 0, 0);
    n_cmp++; if ({rpt_valid, illegal_seen} !== 2'b11 || trans_cnt !== 8'd2) begin n_fail++;
      $display("FAIL arst_pre rv_seen=%b trans=%0d exp=11/2", {rpt_valid, illegal_seen}, trans_cnt); end
    #2 rst_n = 1'b0;
    #1;
    model_clear(); model_expect_cov();
    n_cmp++; if ({trans_cnt, illegal_state, illegal_seen, stuck, rpt_valid, rpt_code, rpt_state, rpt_ovf, visited, all_visited} !== 23'b0) begin
      n_fail++; $display("FAIL arst_now trans=%0d flags=%b", trans_cnt, {illegal_state, illegal_seen, stuck, rpt_valid, rpt_ovf}); end
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 2'd1, 0, 0); step(1, 2'd2, 0, 0);
    n_cmp++; if (trans_cnt !== 8'd1) begin n_fail++; $display("FAIL arst_after_trans got=%0d exp=1", trans_cnt); end
    n_cmp++; if (visited !== exp_vis) begin n_fail++; $display("FAIL arst_after_vis got=%b exp=%b", visited, exp_vis); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_legal_walk();
    test_illegal();
    test_stuck_ovf();
    test_back_to_back();
    test_saturate_clr();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t limit=2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
